defog_frame_ctrl: RTL and testbench

//  Frame-level controller for the dehazing pipeline (dark channel -> transmittance -> recovery).

---
 rtl/defog_frame_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_defog_frame_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/defog_frame_ctrl.sv
// ---------------------------------------------------------------------------
// defog_frame_ctrl
//
// Frame-level controller for the dehazing pipeline (dark channel ->
// transmittance -> recovery). It follows the frame timing, checks the
// active-video geometry of every completed frame, and derives a temporally
// smoothed atmospheric light value from each frame's dark-channel maximum.
// Host configuration is held in a shadow register and only becomes active at
// a frame boundary, so no frame is processed with a mix of old and new
// parameters.
//
// Ports:
//   pixelclk      in   1   pixel clock, the only clock
//   reset_n       in   1   synchronous reset, active HIGH (1 = reset)
//   i_vsync       in   1   frame sync, active high
//   i_de          in   1   active pixel qualifier
//   i_dark        in   8   dark-channel value, valid while i_de = 1
//   cfg_valid     in   1   host config write request
//   cfg_ready     out  1   shadow register can accept a write
//   cfg_thre      in   8   new transmittance threshold
//   cfg_bypass    in   1   new bypass (1 = raw RGB downstream)
//   cfg_atmo_fix  in   1   1 = use cfg_atmo_val instead of the IIR value
//   cfg_atmo_val  in   8   fixed atmospheric light
//   o_thre        out  8   active threshold
//   o_bypass      out  1   active bypass
//   o_atmo        out  8   atmospheric light for the current frame
//   o_frame_done  out  1   one-cycle pulse per completed full frame
//   o_frame_cnt   out  16  completed-frame count, wraps 0xFFFF -> 0
//   o_geom_err    out  1   geometry mismatch of the last completed frame
// ---------------------------------------------------------------------------
module defog_frame_ctrl #(
  parameter int unsigned H_ACT       = 1280,
  parameter int unsigned V_ACT       = 720,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter logic [7:0]  A_MIN       = 8'd100,
  parameter logic [7:0]  THRE_DEF    = 8'd95
) (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic [7:0]  i_dark,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_thre,
  input  logic        cfg_bypass,
  input  logic        cfg_atmo_fix,
  input  logic [7:0]  cfg_atmo_val,
  output logic [7:0]  o_thre,
  output logic        o_bypass,
  output logic [7:0]  o_atmo,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt,
  output logic        o_geom_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(V_ACT);

  state_e            state_q, state_d;
  logic              vsDly_q, deDly_q;
  logic [CNT_W-1:0]  pixCnt_q, lineCnt_q;
  logic              lineErr_q;
  logic [7:0]        frameMax_q;
  logic              first_q, pending_q;
  logic [7:0]        shThre_q, shAtmoVal_q;
  logic              shBypass_q, shAtmoFix_q;
  logic [7:0]        thre_q, atmoVal_q, atmo_q;
  logic              bypass_q, atmoFix_q;
  logic              done_q, geomErr_q;
  logic [15:0]       frameCnt_q;

  logic              vsRise, deFall, cfgAccept;
  logic              fixSel;
  logic [7:0]        fixVal;
  logic signed [8:0] atmoDiff, atmoStep;
  logic signed [9:0] atmoSum;
  logic [7:0]        atmo_d;

  // Edge detectors on the registered copies of vsync and data-enable, plus
  // the config handshake. Ready drops while a write waits in the shadow and
  // during the commit cycle, so the shadow never changes while being applied.
  always_comb begin
    vsRise    = i_vsync & ~vsDly_q;
    deFall    = deDly_q & ~i_de;
    cfg_ready = ~pending_q & (state_q != COMMIT);
    cfgAccept = cfg_valid & cfg_ready;
  end

  // Atmospheric light IIR. The update must see the configuration that takes
  // effect at this commit, so a pending fixed-atmo write wins over the old
  // active one. The step is an arithmetic shift of the signed difference, so
  // it rounds toward minus infinity; the sum is clamped to [A_MIN, 255].
  always_comb begin
    fixSel   = pending_q ? shAtmoFix_q : atmoFix_q;
    fixVal   = pending_q ? shAtmoVal_q : atmoVal_q;
    atmoDiff = $signed({1'b0, frameMax_q}) - $signed({1'b0, atmo_q});
    atmoStep = atmoDiff >>> ALPHA_SHIFT;
    atmoSum  = $signed({2'b00, atmo_q}) + $signed({atmoStep[8], atmoStep});
    if (fixSel) begin
      atmo_d = fixVal;
    end else if (atmoSum < $signed({2'b00, A_MIN})) begin
      atmo_d = A_MIN;
    end else if (atmoSum > 10'sd255) begin
      atmo_d = 8'hFF;
    end else begin
      atmo_d = atmoSum[7:0];
    end
  end

  // Frame FSM next state: each vsync rising edge forces one commit cycle,
  // after which the controller collects statistics for the new frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vsRise) state_d = COMMIT;
      COMMIT:  state_d = ACTIVE;
      ACTIVE:  if (vsRise) state_d = COMMIT;
      default: state_d = IDLE;
    endcase
  end

  // State register and all frame bookkeeping. The commit cycle closes the
  // previous frame (geometry verdict, done pulse, atmo update), applies any
  // pending config and clears the statistics. The first commit after reset
  // closes only a partial frame, so it applies config and nothing else.
  // Counters saturate, and hitting saturation marks the frame as bad.
  always_ff @(posedge pixelclk) begin
    if (reset_n) begin
      state_q     <= IDLE;
      vsDly_q     <= 1'b0;
      deDly_q     <= 1'b0;
      pixCnt_q    <= '0;
      lineCnt_q   <= '0;
      lineErr_q   <= 1'b0;
      frameMax_q  <= 8'd0;
      first_q     <= 1'b1;
      pending_q   <= 1'b0;
      shThre_q    <= 8'd0;
      shBypass_q  <= 1'b0;
      shAtmoFix_q <= 1'b0;
      shAtmoVal_q <= 8'd0;
      thre_q      <= THRE_DEF;
      bypass_q    <= 1'b0;
      atmoFix_q   <= 1'b0;
      atmoVal_q   <= 8'd0;
      atmo_q      <= 8'hFF;
      done_q      <= 1'b0;
      geomErr_q   <= 1'b0;
      frameCnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      vsDly_q <= i_vsync;
      deDly_q <= i_de;
      done_q  <= 1'b0;

      if (cfgAccept) begin
        pending_q   <= 1'b1;
        shThre_q    <= cfg_thre;
        shBypass_q  <= cfg_bypass;
        shAtmoFix_q <= cfg_atmo_fix;
        shAtmoVal_q <= cfg_atmo_val;
      end

      if (state_q == COMMIT) begin
        frameMax_q <= 8'd0;
        pixCnt_q   <= '0;
        lineCnt_q  <= '0;
        lineErr_q  <= 1'b0;
        if (pending_q) begin
          pending_q <= 1'b0;
          thre_q    <= shThre_q;
          bypass_q  <= shBypass_q;
          atmoFix_q <= shAtmoFix_q;
          atmoVal_q <= shAtmoVal_q;
        end
        if (first_q) begin
          first_q <= 1'b0;
        end else begin
          geomErr_q  <= (lineCnt_q != V_EXP) | lineErr_q;
          done_q     <= 1'b1;
          frameCnt_q <= frameCnt_q + 16'd1;
          atmo_q     <= atmo_d;
        end
      end else if (state_q == ACTIVE) begin
        if (i_de) begin
          if (pixCnt_q == CNT_MAX) lineErr_q <= 1'b1;
          else                     pixCnt_q  <= pixCnt_q + 1'b1;
          if (i_dark > frameMax_q) frameMax_q <= i_dark;
        end
        if (deFall) begin
          if (lineCnt_q == CNT_MAX) lineErr_q <= 1'b1;
          else                      lineCnt_q <= lineCnt_q + 1'b1;
          if (pixCnt_q != H_EXP) lineErr_q <= 1'b1;
          pixCnt_q <= '0;
        end
      end
    end
  end

  assign o_thre       = thre_q;
  assign o_bypass     = bypass_q;
  assign o_atmo       = atmo_q;
  assign o_frame_done = done_q;
  assign o_frame_cnt  = frameCnt_q;
  assign o_geom_err   = geomErr_q;

endmodule

// File: tb/tb_defog_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_defog_frame_ctrl
//
// Self-checking bench for defog_frame_ctrl with a small 8x4 frame geometry.
// A frame-level reference model (line lengths, frame maximum, config shadow,
// smoothed atmo value) predicts every output after each frame boundary.
// ---------------------------------------------------------------------------
module tb_defog_frame_ctrl;

  localparam int H_ACT = 8;
  localparam int V_ACT = 4;
  localparam int ASH   = 2;
  localparam int AMIN  = 100;

  logic        clock, reset;
  logic        i_vsync, i_de;
  logic [7:0]  i_dark;
  logic        cfg_valid, cfg_ready;
  logic [7:0]  cfg_thre, cfg_atmo_val;
  logic        cfg_bypass, cfg_atmo_fix;
  logic [7:0]  o_thre, o_atmo;
  logic        o_bypass, o_frame_done, o_geom_err;
  logic [15:0] o_frame_cnt;

  int nChecks = 0;
  int nFails  = 0;
  int doneSeen = 0;

  // reference model state
  int mFirst, mPending;
  int shThre, shBypass, shFix, shVal;
  int mThre, mBypass, mFix, mFixVal, mAtmo, mCnt, mGeom;
  int mDone = 0;
  int fLines, fBad, fMax;

  defog_frame_ctrl #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .CNT_W(12), .ALPHA_SHIFT(ASH),
    .A_MIN(8'd100), .THRE_DEF(8'd95)
  ) dut (
    .pixelclk(clock), .reset_n(reset),
    .i_vsync(i_vsync), .i_de(i_de), .i_dark(i_dark),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_thre(cfg_thre), .cfg_bypass(cfg_bypass),
    .cfg_atmo_fix(cfg_atmo_fix), .cfg_atmo_val(cfg_atmo_val),
    .o_thre(o_thre), .o_bypass(o_bypass), .o_atmo(o_atmo),
    .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
    .o_geom_err(o_geom_err)
  );

  // Free-running pixel clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count done pulses, sampled on the falling edge so each one-cycle pulse
  // is seen exactly once and a stuck-high pulse over-counts.
  always @(negedge clock) begin
    if (o_frame_done) doneSeen <= doneSeen + 1;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Reference: reset returns the model to its power-on state.
  task automatic modelReset();
    mFirst = 1; mPending = 0;
    mThre = 95; mBypass = 0; mFix = 0; mFixVal = 0;
    mAtmo = 255; mCnt = 0; mGeom = 0;
    fLines = 0; fBad = 0; fMax = 0;
  endtask

  // Reference: frame boundary. Smoothing step is floor((max-atmo)/2^ASH).
  task automatic modelCommit();
    int diff, den, step;
    if (mFirst != 0) begin
      mFirst = 0;
      if (mPending != 0) begin
        mThre = shThre; mBypass = shBypass; mFix = shFix; mFixVal = shVal;
        mPending = 0;
      end
    end else begin
      mGeom = ((fLines != V_ACT) || (fBad != 0)) ? 1 : 0;
      mDone++;
      mCnt = (mCnt + 1) % 65536;
      if (mPending != 0) begin
        mThre = shThre; mBypass = shBypass; mFix = shFix; mFixVal = shVal;
        mPending = 0;
      end
      if (mFix != 0) begin
        mAtmo = mFixVal;
      end else begin
        diff = fMax - mAtmo;
        den  = 1 << ASH;
        step = (diff >= 0) ? diff / den : -((-diff + den - 1) / den);
        mAtmo = mAtmo + step;
        if (mAtmo < AMIN) mAtmo = AMIN;
        if (mAtmo > 255) mAtmo = 255;
      end
    end
    fLines = 0; fBad = 0; fMax = 0;
  endtask

  task automatic doReset(input int n);
    @(negedge clock);
    reset = 1'b1; i_de = 1'b0; i_vsync = 1'b0; cfg_valid = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
    modelReset();
  endtask

  // One line of len pixels whose maximum is exactly maxVal, then 2 blanks.
  task automatic sendLine(input int len, input int maxVal);
    int pos;
    pos = $urandom_range(0, len - 1);
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      i_de   = 1'b1;
      i_dark = (i == pos) ? 8'(maxVal) : 8'($urandom_range(0, maxVal));
    end
    @(negedge clock);
    i_de   = 1'b0;
    i_dark = 8'($urandom_range(0, 255));
    @(negedge clock);
    fLines++;
    if (len != H_ACT) fBad = 1;
    if (maxVal > fMax) fMax = maxVal;
  endtask

  // Single-cycle config write; ready is predicted from the model's shadow.
  task automatic cfgPulse(input int thre, input int byp, input int fix, input int val);
    checkOutput("cfg_ready_pre", int'(cfg_ready), (mPending == 0) ? 1 : 0);
    cfg_thre = 8'(thre); cfg_bypass = byp[0];
    cfg_atmo_fix = fix[0]; cfg_atmo_val = 8'(val);
    cfg_valid = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
    if (mPending == 0) begin
      mPending = 1; shThre = thre; shBypass = byp; shFix = fix; shVal = val;
    end
  endtask

  // Frame boundary followed by a full comparison of model and outputs.
  task automatic endFrame();
    @(negedge clock);
    i_vsync = 1'b1;
    @(negedge clock);
    @(negedge clock);
    i_vsync = 1'b0;
    modelCommit();
    repeat (3) @(negedge clock);
    checkOutput("thre", int'(o_thre), mThre);
    checkOutput("bypass", int'(o_bypass), mBypass);
    checkOutput("atmo", int'(o_atmo), mAtmo);
    checkOutput("frame_cnt", int'(o_frame_cnt), mCnt);
    checkOutput("geom_err", int'(o_geom_err), mGeom);
    checkOutput("done_pulses", doneSeen, mDone);
  endtask

  task automatic sendFrame(input int nLines, input int maxVal);
    for (int l = 0; l < nLines; l++) sendLine(H_ACT, maxVal);
    endFrame();
  endtask

  // Randomized frames: occasional wrong line count, wrong line length and
  // config writes with random content.
  task automatic applyStimulus(input int nFrames);
    int nl, bad, cfgAt, len;
    for (int f = 0; f < nFrames; f++) begin
      nl    = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 5) : V_ACT;
      bad   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nl - 1) : -1;
      cfgAt = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nl - 1) : -1;
      for (int l = 0; l < nl; l++) begin
        len = (l == bad) ? (($urandom_range(0, 1) == 1) ? H_ACT - 1 : H_ACT + 1) : H_ACT;
        sendLine(len, $urandom_range(0, 255));
        if (l == cfgAt)
          cfgPulse($urandom_range(0, 255), $urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 255));
      end
      endFrame();
    end
  endtask

  initial begin
    reset = 1'b0; i_vsync = 1'b0; i_de = 1'b0; i_dark = 8'd0;
    cfg_valid = 1'b0; cfg_thre = 8'd0; cfg_bypass = 1'b0;
    cfg_atmo_fix = 1'b0; cfg_atmo_val = 8'd0;

    // Reset values
    doReset(3);
    @(negedge clock);
    checkOutput("rst_thre", int'(o_thre), 95);
    checkOutput("rst_atmo", int'(o_atmo), 255);
    checkOutput("rst_bypass", int'(o_bypass), 0);
    checkOutput("rst_ready", int'(cfg_ready), 1);
    checkOutput("rst_cnt", int'(o_frame_cnt), 0);
    checkOutput("rst_geom", int'(o_geom_err), 0);

    // Geometry: partial first frame, good frame, short frame, short line
    sendFrame(V_ACT, $urandom_range(0, 255));
    checkOutput("geo_first_nodone", doneSeen, 0);
    sendFrame(V_ACT, $urandom_range(0, 255));
    checkOutput("geo_cnt1", int'(o_frame_cnt), 1);
    checkOutput("geo_ok", int'(o_geom_err), 0);
    sendFrame(V_ACT - 1, 50);
    checkOutput("geo_3lines", int'(o_geom_err), 1);
    sendLine(H_ACT, 10); sendLine(H_ACT - 1, 10); sendLine(H_ACT, 10); sendLine(H_ACT, 10);
    endFrame();
    checkOutput("geo_7pix", int'(o_geom_err), 1);
    sendFrame(V_ACT, 77);
    checkOutput("geo_recover", int'(o_geom_err), 0);

    // IIR from 255 with directed frame maxima
    doReset(2);
    sendFrame(V_ACT, 200);
    sendFrame(V_ACT, 155); checkOutput("iir_155", int'(o_atmo), 230);
    sendFrame(V_ACT, 230); checkOutput("iir_230", int'(o_atmo), 230);
    sendFrame(V_ACT, 0);   checkOutput("iir_0a", int'(o_atmo), 172);
    sendFrame(V_ACT, 0);   checkOutput("iir_0b", int'(o_atmo), 129);
    sendFrame(V_ACT, 0);   checkOutput("iir_clamp", int'(o_atmo), 100);

    // Handshake: accepted write waits for commit, second write stalls
    sendLine(H_ACT, 40);
    cfgPulse(8'h60, 0, 0, 0);
    checkOutput("hs_ready_low", int'(cfg_ready), 0);
    checkOutput("hs_thre_hold", int'(o_thre), 95);
    cfg_thre = 8'h33; cfg_bypass = 1'b0; cfg_atmo_fix = 1'b0; cfg_atmo_val = 8'd0;
    cfg_valid = 1'b1;
    sendLine(H_ACT, 40);
    checkOutput("hs_stall_ready", int'(cfg_ready), 0);
    checkOutput("hs_stall_thre", int'(o_thre), 95);
    sendLine(H_ACT, 40); sendLine(H_ACT, 40);
    endFrame();
    checkOutput("hs_thre_new", int'(o_thre), 8'h60);
    cfg_valid = 1'b0;
    mPending = 1; shThre = 8'h33; shBypass = 0; shFix = 0; shVal = 0;
    checkOutput("hs_second_taken", int'(cfg_ready), 0);
    sendFrame(V_ACT, 90);
    checkOutput("hs_thre_second", int'(o_thre), 8'h33);
    checkOutput("hs_ready_free", int'(cfg_ready), 1);

    // Fixed atmo overrides the frame maximum, then smoothing resumes
    sendLine(H_ACT, 255);
    cfgPulse(8'h33, 1, 1, 8'h80);
    sendLine(H_ACT, 255); sendLine(H_ACT, 255); sendLine(H_ACT, 255);
    endFrame();
    checkOutput("fix_atmo", int'(o_atmo), 8'h80);
    checkOutput("fix_bypass", int'(o_bypass), 1);
    sendLine(H_ACT, 8'h80);
    cfgPulse(8'h33, 0, 0, 0);
    sendLine(H_ACT, 8'h80); sendLine(H_ACT, 8'h80); sendLine(H_ACT, 8'h80);
    endFrame();
    checkOutput("fix_release", int'(o_atmo), 8'h80);

    // Reset in the middle of a frame with a write pending
    sendLine(H_ACT, 60);
    cfgPulse(8'h44, 1, 0, 0);
    sendLine(H_ACT, 60);
    doReset(2);
    @(negedge clock);
    checkOutput("mid_rst_thre", int'(o_thre), 95);
    checkOutput("mid_rst_ready", int'(cfg_ready), 1);
    checkOutput("mid_rst_cnt", int'(o_frame_cnt), 0);
    sendFrame(V_ACT, 120);
    checkOutput("mid_rst_cnt0", int'(o_frame_cnt), 0);
    checkOutput("mid_rst_thre_kept", int'(o_thre), 95);
    sendFrame(V_ACT, 120);
    checkOutput("mid_rst_cnt1", int'(o_frame_cnt), 1);

    // Randomized frames against the model
    applyStimulus(24);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
